// File: rtl/mult_dispatch.sv
// mult_dispatch: operand FIFO plus one-job-at-a-time issue/capture wrapper
// around a start/done shift-add multiplier, exposing valid/ready on both sides.
//
// Handshake semantics (both streaming ports): a transfer happens on a rising
// clk edge where valid && ready are both 1; valid, once raised, and its data
// stay stable until that edge; ready never depends combinationally on valid.
//
// Optional feature: define MULT_DISPATCH_ZERO_SKIP_EN to bypass the multiplier
// for jobs with a zero operand (result 0, no mul_start issued).
module mult_dispatch #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_a,
  input  logic [WIDTH-1:0]       in_b,
  output logic                   mul_start,
  output logic [WIDTH-1:0]       mul_a,
  output logic [WIDTH-1:0]       mul_b,
  input  logic [2*WIDTH-1:0]     mul_product,
  input  logic                   mul_done,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2*WIDTH-1:0]     out_product,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] count,
  output logic [2:0]             dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE  = 3'd1,
    WAIT   = 3'd2,
    SETTLE = 3'd3,
    HOLD   = 3'd4
  } state_t;

  state_t           state;
  logic             done_q;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [WIDTH-1:0] mem_a [DEPTH];
  logic [WIDTH-1:0] mem_b [DEPTH];
  logic [WIDTH-1:0] head_a;
  logic [WIDTH-1:0] head_b;
  logic             head_zero;
  logic             push;
  logic             pop;

  assign in_ready  = (count != CW'(DEPTH));
  assign push      = in_valid && in_ready;
  // The FIFO is only drained by IDLE, one job at a time.
  assign pop       = (state == IDLE) && (count != '0);
  assign head_a    = mem_a[rd_ptr];
  assign head_b    = mem_b[rd_ptr];
  assign busy      = (state != IDLE);
  assign dbg_state = state;

`ifdef MULT_DISPATCH_ZERO_SKIP_EN
  assign head_zero = (head_a == '0) || (head_b == '0);
`else
  assign head_zero = 1'b0;
`endif

  // Operand storage: written on push, no reset needed (guarded by count).
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr] <= in_a;
      mem_b[wr_ptr] <= in_b;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is 2^AW.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Issue/capture FSM with registered start pulse, operands and result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      done_q      <= 1'b0;
      mul_start   <= 1'b0;
      mul_a       <= '0;
      mul_b       <= '0;
      out_valid   <= 1'b0;
      out_product <= '0;
    end else begin
      // Registered every cycle so a done level left over from the previous
      // job is never mistaken for a fresh completion.
      done_q    <= mul_done;
      mul_start <= 1'b0;
      case (state)
        IDLE: begin
          if (count != '0) begin
            if (head_zero) begin
              out_product <= '0;
              out_valid   <= 1'b1;
              state       <= HOLD;
            end else begin
              mul_a     <= head_a;
              mul_b     <= head_b;
              mul_start <= 1'b1;
              state     <= ISSUE;
            end
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          if (mul_done && !done_q) state <= SETTLE;
        end
        SETTLE: begin
          out_product <= mul_product;
          out_valid   <= 1'b1;
          state       <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
